// File: rtl/vscale_hasti_arbiter_pkg.sv
// Types and helpers shared by the two-master HASTI arbiter and its hold registers.
`include "vscale_hasti_constants.vh"

package vscale_hasti_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_e;

    localparam int ARB_FIXED       = 0;
    localparam int ARB_ROUND_ROBIN = 1;

    localparam logic [1:0] HTRANS_IDLE   = `HASTI_TRANS_IDLE;
    localparam logic [1:0] HTRANS_BUSY   = `HASTI_TRANS_BUSY;
    localparam logic [1:0] HTRANS_NONSEQ = `HASTI_TRANS_NONSEQ;
    localparam logic [1:0] HTRANS_SEQ    = `HASTI_TRANS_SEQ;

    localparam logic [2:0] HSIZE_WORD    = `HASTI_SIZE_WORD;
    localparam logic [2:0] HBURST_SINGLE = `HASTI_BURST_SINGLE;

    localparam logic HRESP_OKAY  = `HASTI_RESP_OKAY;
    localparam logic HRESP_ERROR = `HASTI_RESP_ERROR;

    // BUSY and IDLE never start a transfer on the slave.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

    function automatic owner_e owner_of(input logic m);
        return m ? OWNER_M1 : OWNER_M0;
    endfunction

endpackage

// File: rtl/vscale_hasti_constants.vh
// Shared HASTI (AHB-lite) field encodings used by the vscale bus blocks.
`ifndef VSCALE_HASTI_CONSTANTS_VH
`define VSCALE_HASTI_CONSTANTS_VH

`define HASTI_TRANS_WIDTH   2
`define HASTI_TRANS_IDLE    2'd0
`define HASTI_TRANS_BUSY    2'd1
`define HASTI_TRANS_NONSEQ  2'd2
`define HASTI_TRANS_SEQ     2'd3

`define HASTI_SIZE_WIDTH    3
`define HASTI_SIZE_BYTE     3'd0
`define HASTI_SIZE_HALFWORD 3'd1
`define HASTI_SIZE_WORD     3'd2

`define HASTI_BURST_WIDTH   3
`define HASTI_BURST_SINGLE  3'd0
`define HASTI_BURST_INCR    3'd1

`define HASTI_PROT_WIDTH    4

`define HASTI_RESP_WIDTH    1
`define HASTI_RESP_OKAY     1'b0
`define HASTI_RESP_ERROR    1'b1

`endif

// File: rtl/vscale_hasti_hold_reg.sv
// One-deep address-phase capture for a master that lost arbitration, plus the
// live/held mux that presents whichever address phase this master is requesting.
`include "vscale_hasti_constants.vh"

module vscale_hasti_hold_reg
    import vscale_hasti_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  live_ready,
    input  logic                  capture,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic                  hmastlock,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    output logic                  pend,
    output logic                  live_req,
    output logic                  req,
    output logic [ADDR_WIDTH-1:0] sel_haddr,
    output logic                  sel_hwrite,
    output logic [2:0]            sel_hsize,
    output logic [2:0]            sel_hburst,
    output logic                  sel_hmastlock,
    output logic [3:0]            sel_hprot,
    output logic [1:0]            sel_htrans
);

    logic [ADDR_WIDTH-1:0] hold_haddr;
    logic                  hold_hwrite;
    logic [2:0]            hold_hsize;
    logic [2:0]            hold_hburst;
    logic                  hold_hmastlock;
    logic [3:0]            hold_hprot;
    logic [1:0]            hold_htrans;

    // A live request only exists while the master sees hready high.
    assign live_req = trans_active(htrans) && live_ready;
    assign req      = pend || live_req;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend <= 1'b0;
        end else if (capture) begin
            pend <= 1'b1;
        end else if (issue) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        if (capture) begin
            hold_haddr     <= haddr;
            hold_hwrite    <= hwrite;
            hold_hsize     <= hsize;
            hold_hburst    <= hburst;
            hold_hmastlock <= hmastlock;
            hold_hprot     <= hprot;
            hold_htrans    <= htrans;
        end
    end

    always_comb begin
        if (pend) begin
            sel_haddr     = hold_haddr;
            sel_hwrite    = hold_hwrite;
            sel_hsize     = hold_hsize;
            sel_hburst    = hold_hburst;
            sel_hmastlock = hold_hmastlock;
            sel_hprot     = hold_hprot;
            sel_htrans    = hold_htrans;
        end else begin
            sel_haddr     = haddr;
            sel_hwrite    = hwrite;
            sel_hsize     = hsize;
            sel_hburst    = hburst;
            sel_hmastlock = hmastlock;
            sel_hprot     = hprot;
            sel_htrans    = htrans;
        end
    end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (imem/dmem) to one-slave HASTI arbiter: zero-latency pass-through
// when uncontended, one-deep hold per master and hready stall when it loses.
`include "vscale_hasti_constants.vh"

module vscale_hasti_arbiter
    import vscale_hasti_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,

    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic                  m0_hwrite,
    input  logic [2:0]            m0_hsize,
    input  logic [2:0]            m0_hburst,
    input  logic                  m0_hmastlock,
    input  logic [3:0]            m0_hprot,
    input  logic [1:0]            m0_htrans,
    input  logic [DATA_WIDTH-1:0] m0_hwdata,
    output logic [DATA_WIDTH-1:0] m0_hrdata,
    output logic                  m0_hready,
    output logic                  m0_hresp,

    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic                  m1_hwrite,
    input  logic [2:0]            m1_hsize,
    input  logic [2:0]            m1_hburst,
    input  logic                  m1_hmastlock,
    input  logic [3:0]            m1_hprot,
    input  logic [1:0]            m1_htrans,
    input  logic [DATA_WIDTH-1:0] m1_hwdata,
    output logic [DATA_WIDTH-1:0] m1_hrdata,
    output logic                  m1_hready,
    output logic                  m1_hresp,

    output logic [ADDR_WIDTH-1:0] s_haddr,
    output logic                  s_hwrite,
    output logic [2:0]            s_hsize,
    output logic [2:0]            s_hburst,
    output logic                  s_hmastlock,
    output logic [3:0]            s_hprot,
    output logic [1:0]            s_htrans,
    output logic [DATA_WIDTH-1:0] s_hwdata,
    input  logic [DATA_WIDTH-1:0] s_hrdata,
    input  logic                  s_hready,
    input  logic                  s_hresp
);

    owner_e data_owner;
    logic   last_grant;
    logic   stick_vld;
    logic   stick_m;

    logic [1:0] pend;
    logic [1:0] live_req;
    logic [1:0] req;
    logic [1:0] capture;
    logic [1:0] grant;
    logic       sel_vld;
    logic       sel_m;
    logic       issue;

    logic [ADDR_WIDTH-1:0] c_haddr     [2];
    logic                  c_hwrite    [2];
    logic [2:0]            c_hsize     [2];
    logic [2:0]            c_hburst    [2];
    logic                  c_hmastlock [2];
    logic [3:0]            c_hprot     [2];
    logic [1:0]            c_htrans    [2];

    vscale_hasti_hold_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold0 (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .live_ready    (m0_hready),
        .capture       (capture[0]),
        .issue         (grant[0]),
        .haddr         (m0_haddr),
        .hwrite        (m0_hwrite),
        .hsize         (m0_hsize),
        .hburst        (m0_hburst),
        .hmastlock     (m0_hmastlock),
        .hprot         (m0_hprot),
        .htrans        (m0_htrans),
        .pend          (pend[0]),
        .live_req      (live_req[0]),
        .req           (req[0]),
        .sel_haddr     (c_haddr[0]),
        .sel_hwrite    (c_hwrite[0]),
        .sel_hsize     (c_hsize[0]),
        .sel_hburst    (c_hburst[0]),
        .sel_hmastlock (c_hmastlock[0]),
        .sel_hprot     (c_hprot[0]),
        .sel_htrans    (c_htrans[0])
    );

    vscale_hasti_hold_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold1 (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .live_ready    (m1_hready),
        .capture       (capture[1]),
        .issue         (grant[1]),
        .haddr         (m1_haddr),
        .hwrite        (m1_hwrite),
        .hsize         (m1_hsize),
        .hburst        (m1_hburst),
        .hmastlock     (m1_hmastlock),
        .hprot         (m1_hprot),
        .htrans        (m1_htrans),
        .pend          (pend[1]),
        .live_req      (live_req[1]),
        .req           (req[1]),
        .sel_haddr     (c_haddr[1]),
        .sel_hwrite    (c_hwrite[1]),
        .sel_hsize     (c_hsize[1]),
        .sel_hburst    (c_hburst[1]),
        .sel_hmastlock (c_hmastlock[1]),
        .sel_hprot     (c_hprot[1]),
        .sel_htrans    (c_htrans[1])
    );

    // A held master is stalled; the data-phase owner follows the slave.
    always_comb begin
        m0_hready = 1'b1;
        if (pend[0]) begin
            m0_hready = 1'b0;
        end else if (data_owner == OWNER_M0) begin
            m0_hready = s_hready;
        end
        m1_hready = 1'b1;
        if (pend[1]) begin
            m1_hready = 1'b0;
        end else if (data_owner == OWNER_M1) begin
            m1_hready = s_hready;
        end
    end

    // The address chosen during a slave wait stays on the bus until accepted.
    always_comb begin
        sel_vld = |req;
        if (stick_vld && req[stick_m]) begin
            sel_m = stick_m;
        end else if (req == 2'b11) begin
            sel_m = (ARB_MODE == ARB_ROUND_ROBIN) ? ~last_grant : 1'b1;
        end else begin
            sel_m = req[1];
        end
    end

    assign issue      = sel_vld && s_hready;
    assign grant[0]   = issue && !sel_m;
    assign grant[1]   = issue && sel_m;
    // A live address the slave did not accept has been taken from the master anyway.
    assign capture[0] = live_req[0] && !grant[0];
    assign capture[1] = live_req[1] && !grant[1];

    always_comb begin
        s_haddr     = '0;
        s_hwrite    = 1'b0;
        s_hsize     = '0;
        s_hburst    = '0;
        s_hmastlock = 1'b0;
        s_hprot     = '0;
        s_htrans    = HTRANS_IDLE;
        if (sel_vld) begin
            s_haddr     = c_haddr[sel_m];
            s_hwrite    = c_hwrite[sel_m];
            s_hsize     = c_hsize[sel_m];
            s_hburst    = c_hburst[sel_m];
            s_hmastlock = c_hmastlock[sel_m];
            s_hprot     = c_hprot[sel_m];
            s_htrans    = c_htrans[sel_m];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            data_owner <= OWNER_NONE;
            last_grant <= 1'b0;
            stick_vld  <= 1'b0;
            stick_m    <= 1'b0;
        end else begin
            if (s_hready) begin
                data_owner <= issue ? owner_of(sel_m) : OWNER_NONE;
            end
            if (issue) begin
                last_grant <= sel_m;
            end
            stick_vld <= sel_vld && !s_hready;
            stick_m   <= sel_m;
        end
    end

    always_comb begin
        s_hwdata = '0;
        m0_hresp = HRESP_OKAY;
        m1_hresp = HRESP_OKAY;
        case (data_owner)
            OWNER_M0: begin
                s_hwdata = m0_hwdata;
                m0_hresp = s_hresp;
            end
            OWNER_M1: begin
                s_hwdata = m1_hwdata;
                m1_hresp = s_hresp;
            end
            default: ;
        endcase
    end

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: fixed-priority instance with a small
// SRAM-like slave, plus a round-robin instance driven with a permanent slave.
module tb_vscale_hasti_arbiter;
    import vscale_hasti_arbiter_pkg::*;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
    logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
    logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;
    logic [1:0]  s_htrans;

    logic [31:0] r_m0_haddr, r_m1_haddr, r_m0_hrdata, r_m1_hrdata, r_s_haddr, r_s_hwdata;
    logic [1:0]  r_m0_htrans, r_m1_htrans, r_s_htrans;
    logic        r_m0_hready, r_m1_hready, r_m0_hresp, r_m1_hresp;
    logic        r_s_hwrite, r_s_hmastlock;
    logic [2:0]  r_s_hsize, r_s_hburst;
    logic [3:0]  r_s_hprot;

    vscale_hasti_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
        .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
        .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
        .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
        .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans),
        .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    vscale_hasti_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_rr (
        .hclk(hclk), .hresetn(hresetn),
        .m0_haddr(r_m0_haddr), .m0_hwrite(1'b0), .m0_hsize(HSIZE_WORD), .m0_hburst(HBURST_SINGLE),
        .m0_hmastlock(1'b0), .m0_hprot(4'h1), .m0_htrans(r_m0_htrans),
        .m0_hwdata(32'h0), .m0_hrdata(r_m0_hrdata), .m0_hready(r_m0_hready), .m0_hresp(r_m0_hresp),
        .m1_haddr(r_m1_haddr), .m1_hwrite(1'b0), .m1_hsize(HSIZE_WORD), .m1_hburst(HBURST_SINGLE),
        .m1_hmastlock(1'b0), .m1_hprot(4'h3), .m1_htrans(r_m1_htrans),
        .m1_hwdata(32'h0), .m1_hrdata(r_m1_hrdata), .m1_hready(r_m1_hready), .m1_hresp(r_m1_hresp),
        .s_haddr(r_s_haddr), .s_hwrite(r_s_hwrite), .s_hsize(r_s_hsize), .s_hburst(r_s_hburst),
        .s_hmastlock(r_s_hmastlock), .s_hprot(r_s_hprot), .s_htrans(r_s_htrans),
        .s_hwdata(r_s_hwdata), .s_hrdata(32'h0), .s_hready(1'b1), .s_hresp(1'b0)
    );

    // Slave model: word memory, reset contents are 0xC0DE0000 | byte address.
    logic [31:0] mem [0:255];
    logic        dph_valid;
    logic        dph_write;
    logic [31:0] dph_addr;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            dph_addr  <= 32'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | (i * 4);
        end else if (s_hready) begin
            if (dph_valid && dph_write) mem[dph_addr[9:2]] <= s_hwdata;
            dph_valid <= s_htrans[1];
            dph_write <= s_hwrite;
            dph_addr  <= s_haddr;
        end
    end
    assign s_hrdata = dph_valid ? mem[dph_addr[9:2]] : 32'h0;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic m0_drive(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
        m0_htrans = trans;
        m0_haddr  = addr;
        m0_hwrite = wr;
    endtask

    task automatic m1_drive(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
        m1_htrans = trans;
        m1_haddr  = addr;
        m1_hwrite = wr;
    endtask

    initial begin
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m0_hsize = HSIZE_WORD;  m1_hsize = HSIZE_WORD;
        m0_hburst = HBURST_SINGLE; m1_hburst = HBURST_SINGLE;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
        m0_hprot = 4'h1; m1_hprot = 4'h3;
        m0_hwdata = 32'h0; m1_hwdata = 32'h0;
        s_hready = 1'b1; s_hresp = 1'b0;
        r_m0_htrans = HTRANS_IDLE; r_m1_htrans = HTRANS_IDLE;
        r_m0_haddr = 32'h300; r_m1_haddr = 32'h400;

        // reset state
        tick(); tick();
        check("rst_s_htrans", s_htrans, HTRANS_IDLE);
        check("rst_m0_hready", m0_hready, 1'b1);
        check("rst_m1_hready", m1_hready, 1'b1);
        check("rst_m0_hresp", m0_hresp, 1'b0);
        check("rst_rr_s_htrans", r_s_htrans, HTRANS_IDLE);
        hresetn = 1'b1;
        tick();

        // uncontended m0 read
        m0_drive(HTRANS_NONSEQ, 32'h100, 1'b0);
        #2;
        check("t1_s_haddr", s_haddr, 32'h100);
        check("t1_s_htrans", s_htrans, HTRANS_NONSEQ);
        check("t1_m0_hready_a", m0_hready, 1'b1);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        #2;
        check("t1_m0_hready_d", m0_hready, 1'b1);
        check("t1_m0_hrdata", m0_hrdata, 32'hC0DE_0100);
        check("t1_s_htrans_idle", s_htrans, HTRANS_IDLE);
        tick();

        // contention, fixed priority: m1 write first, m0 replayed from hold
        m0_drive(HTRANS_NONSEQ, 32'h100, 1'b0);
        m1_drive(HTRANS_NONSEQ, 32'h200, 1'b1);
        #2;
        check("t2_s_haddr_m1", s_haddr, 32'h200);
        check("t2_s_hwrite_m1", s_hwrite, 1'b1);
        check("t2_s_hprot_m1", s_hprot, 4'h3);
        check("t2_m0_hready_a", m0_hready, 1'b1);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_hwdata = 32'hDEAD_BEEF;
        #2;
        check("t2_m0_stall", m0_hready, 1'b0);
        check("t2_m1_hready", m1_hready, 1'b1);
        check("t2_s_haddr_hold", s_haddr, 32'h100);
        check("t2_s_htrans_hold", s_htrans, HTRANS_NONSEQ);
        check("t2_s_hwrite_hold", s_hwrite, 1'b0);
        check("t2_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
        tick();
        m1_hwdata = 32'h0;
        #2;
        check("t2_m0_hready_d", m0_hready, 1'b1);
        check("t2_m0_hrdata", m0_hrdata, 32'hC0DE_0100);
        check("t2_s_htrans_idle", s_htrans, HTRANS_IDLE);
        tick();
        m0_drive(HTRANS_NONSEQ, 32'h200, 1'b0);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        #2;
        check("t2_mem_readback", m0_hrdata, 32'hDEAD_BEEF);
        tick();

        // slave wait states during m1 data phase with m0 pending
        m0_drive(HTRANS_NONSEQ, 32'h108, 1'b0);
        m1_drive(HTRANS_NONSEQ, 32'h204, 1'b1);
        #2;
        check("t4_s_haddr_m1", s_haddr, 32'h204);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_hwdata = 32'h1234_5678;
        for (int w = 0; w < 2; w++) begin
            s_hready = 1'b0;
            #2;
            check($sformatf("t4_wait%0d_s_haddr", w), s_haddr, 32'h108);
            check($sformatf("t4_wait%0d_s_htrans", w), s_htrans, HTRANS_NONSEQ);
            check($sformatf("t4_wait%0d_m0_hready", w), m0_hready, 1'b0);
            check($sformatf("t4_wait%0d_m1_hready", w), m1_hready, 1'b0);
            check($sformatf("t4_wait%0d_s_hwdata", w), s_hwdata, 32'h1234_5678);
            tick();
        end
        s_hready = 1'b1;
        #2;
        check("t4_issue_s_haddr", s_haddr, 32'h108);
        check("t4_issue_m1_hready", m1_hready, 1'b1);
        check("t4_issue_m0_hready", m0_hready, 1'b0);
        tick();
        m1_hwdata = 32'h0;
        #2;
        check("t4_m0_hready_d", m0_hready, 1'b1);
        check("t4_m0_hrdata", m0_hrdata, 32'hC0DE_0108);
        tick();

        // two-cycle ERROR to m0 while m1 becomes pending
        m0_drive(HTRANS_NONSEQ, 32'h10C, 1'b0);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_drive(HTRANS_NONSEQ, 32'h110, 1'b0);
        s_hready = 1'b0; s_hresp = 1'b1;
        #2;
        check("t5_err1_m0_hresp", m0_hresp, 1'b1);
        check("t5_err1_m0_hready", m0_hready, 1'b0);
        check("t5_err1_m1_hresp", m1_hresp, 1'b0);
        tick();
        m1_drive(HTRANS_IDLE, 32'h0, 1'b0);
        s_hready = 1'b1;
        #2;
        check("t5_err2_m0_hresp", m0_hresp, 1'b1);
        check("t5_err2_m0_hready", m0_hready, 1'b1);
        check("t5_err2_m1_hresp", m1_hresp, 1'b0);
        check("t5_err2_m1_hready", m1_hready, 1'b0);
        check("t5_err2_s_haddr", s_haddr, 32'h110);
        tick();
        s_hresp = 1'b0;
        #2;
        check("t5_m0_hresp_clr", m0_hresp, 1'b0);
        check("t5_m1_hready", m1_hready, 1'b1);
        check("t5_m1_hrdata", m1_hrdata, 32'hC0DE_0110);
        tick();

        // asynchronous reset with m0 pending and m1 owning the data phase
        m0_drive(HTRANS_NONSEQ, 32'h114, 1'b0);
        m1_drive(HTRANS_NONSEQ, 32'h118, 1'b0);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        m1_drive(HTRANS_IDLE, 32'h0, 1'b0);
        #1;
        check("t6_pre_m0_stall", m0_hready, 1'b0);
        s_hready = 1'b0; s_hresp = 1'b1;
        hresetn = 1'b0;
        #1;
        check("t6_rst_s_htrans", s_htrans, HTRANS_IDLE);
        check("t6_rst_m0_hready", m0_hready, 1'b1);
        check("t6_rst_m1_hready", m1_hready, 1'b1);
        check("t6_rst_m0_hresp", m0_hresp, 1'b0);
        check("t6_rst_m1_hresp", m1_hresp, 1'b0);
        tick();
        hresetn = 1'b1; s_hready = 1'b1; s_hresp = 1'b0;
        tick();
        m0_drive(HTRANS_NONSEQ, 32'h11C, 1'b0);
        #2;
        check("t6_post_s_haddr", s_haddr, 32'h11C);
        tick();
        m0_drive(HTRANS_IDLE, 32'h0, 1'b0);
        #2;
        check("t6_post_m0_hready", m0_hready, 1'b1);
        check("t6_post_m0_hrdata", m0_hrdata, 32'hC0DE_011C);
        tick();

        // round-robin instance, both masters requesting every cycle
        r_m0_htrans = HTRANS_NONSEQ;
        r_m1_htrans = HTRANS_NONSEQ;
        for (int i = 0; i < 6; i++) begin
            #2;
            check($sformatf("rr%0d_s_haddr", i), r_s_haddr, (i % 2 == 0) ? 32'h400 : 32'h300);
            check($sformatf("rr%0d_m0_hready", i), r_m0_hready, (i % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("rr%0d_m1_hready", i), r_m1_hready, (i == 0 || i % 2 == 1) ? 1'b1 : 1'b0);
            tick();
        end
        r_m0_htrans = HTRANS_IDLE;
        r_m1_htrans = HTRANS_IDLE;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
